// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-ported memory between fetch (IF) and load/store (MEM).
// Define MEM_ARB_RR_EN for round-robin arbitration instead of fixed MEM priority.
module mem_port_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_done,
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              mem_done,
  output logic              stall_if,
  output logic              stall_mem,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  input  logic              ram_ack
);

  typedef enum logic [1:0] {
    IDLE,
    BUSY_IF,
    BUSY_MEM
  } state_e;

  state_e            state_q, state_d;
  logic              ram_en_q, ram_en_d;
  logic              ram_we_q, ram_we_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] mem_rdata_q, mem_rdata_d;
  logic              if_done_q, if_done_d;
  logic              mem_done_q, mem_done_d;

  logic if_elig, mem_elig;
  logic grant_if, grant_mem;

  // A requester whose done pulse is high is completing, not asking again.
  assign if_elig  = if_req & ~if_done_q;
  assign mem_elig = mem_req & ~mem_done_q;

`ifdef MEM_ARB_RR_EN
  localparam logic LG_IF  = 1'b0;
  localparam logic LG_MEM = 1'b1;

  logic last_grant_q, last_grant_d;

  // Under contention the requester not served last wins.
  assign grant_mem = mem_elig & (~if_elig | (last_grant_q == LG_IF));
  assign grant_if  = if_elig & ~grant_mem;

  // Remember who was granted most recently.
  always_comb begin
    last_grant_d = last_grant_q;
    if (state_q == IDLE) begin
      if (grant_mem)     last_grant_d = LG_MEM;
      else if (grant_if) last_grant_d = LG_IF;
    end
  end

  // Round-robin history register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) last_grant_q <= LG_IF;
    else       last_grant_q <= last_grant_d;
  end
`else
  // Older instruction (MEM) always wins.
  assign grant_mem = mem_elig;
  assign grant_if  = if_elig & ~mem_elig;
`endif

  // Next-state and registered-output logic for the grant FSM.
  always_comb begin
    state_d     = state_q;
    ram_en_d    = ram_en_q;
    ram_we_d    = ram_we_q;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    if_rdata_d  = if_rdata_q;
    mem_rdata_d = mem_rdata_q;
    if_done_d   = 1'b0;
    mem_done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (grant_mem) begin
          state_d     = BUSY_MEM;
          ram_en_d    = 1'b1;
          ram_we_d    = mem_we;
          ram_addr_d  = mem_addr;
          ram_wdata_d = mem_wdata;
        end else if (grant_if) begin
          state_d    = BUSY_IF;
          ram_en_d   = 1'b1;
          ram_we_d   = 1'b0;
          ram_addr_d = if_addr;
        end
      end
      BUSY_IF: begin
        if (ram_ack) begin
          state_d    = IDLE;
          ram_en_d   = 1'b0;
          ram_we_d   = 1'b0;
          if_rdata_d = ram_rdata;
          if_done_d  = 1'b1;
        end
      end
      BUSY_MEM: begin
        if (ram_ack) begin
          state_d    = IDLE;
          ram_en_d   = 1'b0;
          ram_we_d   = 1'b0;
          mem_done_d = 1'b1;
          if (!ram_we_q) mem_rdata_d = ram_rdata;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset abandons any access in flight.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      ram_en_q    <= 1'b0;
      ram_we_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      if_rdata_q  <= '0;
      mem_rdata_q <= '0;
      if_done_q   <= 1'b0;
      mem_done_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      ram_en_q    <= ram_en_d;
      ram_we_q    <= ram_we_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
      if_rdata_q  <= if_rdata_d;
      mem_rdata_q <= mem_rdata_d;
      if_done_q   <= if_done_d;
      mem_done_q  <= mem_done_d;
    end
  end

  assign ram_en    = ram_en_q;
  assign ram_we    = ram_we_q;
  assign ram_addr  = ram_addr_q;
  assign ram_wdata = ram_wdata_q;
  assign if_rdata  = if_rdata_q;
  assign mem_rdata = mem_rdata_q;
  assign if_done   = if_done_q;
  assign mem_done  = mem_done_q;

  assign stall_mem = mem_req & ~mem_done_q;
  assign stall_if  = (if_req & ~if_done_q) | stall_mem;

`ifndef SYNTHESIS
  a_if_held: assert property (@(posedge clock) disable iff (reset)
    (state_q == BUSY_IF) |-> if_req);
  a_mem_held: assert property (@(posedge clock) disable iff (reset)
    (state_q == BUSY_MEM) |-> mem_req);
`endif

endmodule
